// File: rtl/servo_pwm_decoder_pkg.sv
// servo_pwm_decoder_pkg: shared servo timing constants and decoder state encoding
package servo_pwm_decoder_pkg;
  localparam int CLK_HZ = 50_000_000;
  localparam int PULSE_MIN = CLK_HZ / 2000;
  localparam int PULSE_MAX = CLK_HZ / 400;
  localparam int STEP = (PULSE_MAX - PULSE_MIN) / 1024;
  localparam int TOL = 2500;
  localparam int TIMEOUT = CLK_HZ / 25;
  localparam int LOCK_CNT = 3;
  localparam int DIV_BITS = 18;
  localparam int GAP_BITS = 21;
  localparam int STEP_BITS = 8;
  localparam int ANGLE_BITS = 10;
  localparam int ANGLE_MAX = 1023;
  typedef enum logic [1:0] {IDLE, HIGH, STUCK, LOW} state_t;
endpackage

// File: rtl/servo_pwm_decoder_if.sv
// servo_pwm_decoder_if: PWM input plus decoded angle/status outputs
interface servo_pwm_decoder_if;
  import servo_pwm_decoder_pkg::*;
  logic iPwm;
  logic [ANGLE_BITS-1:0] oAngle;
  logic oValid;
  logic oErr;
  logic oLocked;
  modport master (output iPwm, input oAngle, oValid, oErr, oLocked);
  modport slave (input iPwm, output oAngle, oValid, oErr, oLocked);
endinterface

// File: rtl/servo_pwm_decoder_div.sv
// servo_pwm_decoder_div: sequential restoring divider, one quotient bit per clock
module servo_pwm_decoder_div
  import servo_pwm_decoder_pkg::*;
#(
  parameter int W = DIV_BITS
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic                 start,
  input  logic [W-1:0]         dividend,
  input  logic [STEP_BITS-1:0] divisor,
  output logic                 busy,
  output logic                 done,
  output logic [W-1:0]         quotient
);
  localparam int CB = $clog2(W + 1);
  logic busy_q, busy_d, done_q, done_d;
  logic [CB-1:0] cnt_q, cnt_d;
  logic [W-1:0] acc_q, acc_d, quo_q, quo_d;
  logic [STEP_BITS-1:0] rem_q, rem_d;
  logic [STEP_BITS:0] trial, diff;
  logic ge;
  // shift one dividend bit into the remainder per clock; starts while busy are ignored
  always_comb begin
    trial = {rem_q, acc_q[W-1]};
    diff = trial - {1'b0, divisor};
    ge = trial >= {1'b0, divisor};
    busy_d = busy_q;
    done_d = 1'b0;
    cnt_d = cnt_q;
    acc_d = acc_q;
    rem_d = rem_q;
    quo_d = quo_q;
    if (!busy_q) begin
      if (start) begin
        busy_d = 1'b1;
        cnt_d = '0;
        acc_d = dividend;
        rem_d = '0;
      end
    end else if (cnt_q == CB'(W)) begin
      busy_d = 1'b0;
      done_d = 1'b1;
      quo_d = acc_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
      acc_d = {acc_q[W-2:0], ge};
      rem_d = STEP_BITS'(ge ? diff : trial);
    end
  end
  // divider state register; reset aborts any division in flight
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q <= '0;
      acc_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign quotient = quo_q;
endmodule

// File: rtl/servo_pwm_decoder.sv
// servo_pwm_decoder: measures servo pulse high time and converts it to a 10-bit angle code
module servo_pwm_decoder
  import servo_pwm_decoder_pkg::*;
#(
  parameter int PULSE_MIN = servo_pwm_decoder_pkg::PULSE_MIN,
  parameter int PULSE_MAX = servo_pwm_decoder_pkg::PULSE_MAX,
  parameter int STEP      = servo_pwm_decoder_pkg::STEP,
  parameter int TOL       = servo_pwm_decoder_pkg::TOL,
  parameter int TIMEOUT   = servo_pwm_decoder_pkg::TIMEOUT,
  parameter int LOCK_CNT  = servo_pwm_decoder_pkg::LOCK_CNT,
  parameter int DIV_BITS  = servo_pwm_decoder_pkg::DIV_BITS
) (
  input logic iClk,
  input logic iRst_n,
  servo_pwm_decoder_if.slave bus
);
  localparam int W = DIV_BITS;
  localparam int RB = $clog2(LOCK_CNT + 1);
  localparam logic [W-1:0] W_LO = W'(PULSE_MIN - TOL);
  localparam logic [W-1:0] W_HI = W'(PULSE_MAX + TOL);
  localparam logic [W-1:0] W_MIN = W'(PULSE_MIN);
  localparam logic [W-1:0] W_MAX = W'(PULSE_MAX);
  localparam logic [W-1:0] W_ANG = W'(ANGLE_MAX);
  localparam logic [GAP_BITS-1:0] GAP_TO = GAP_BITS'(TIMEOUT);
  localparam logic [RB-1:0] RUN_FULL = RB'(LOCK_CNT);
  logic [2:0] sync_q, sync_d;
  state_t state_q, state_d;
  logic [W-1:0] width_q, width_d;
  logic [GAP_BITS-1:0] gap_q, gap_d;
  logic [RB-1:0] run_q, run_d;
  logic [ANGLE_BITS-1:0] angle_q, angle_d;
  logic valid_q, valid_d, err_q, err_d, pend_q, pend_d;
  logic rise, fall, timeout, err_req, err_any, start, busy, done;
  logic [W-1:0] clamp, quo;
  servo_pwm_decoder_div #(.W(W)) u_div (
    .iClk(iClk),
    .iRst_n(iRst_n),
    .start(start),
    .dividend(clamp - W_MIN),
    .divisor(STEP_BITS'(STEP)),
    .busy(busy),
    .done(done),
    .quotient(quo)
  );
  // pulse FSM, width/gap counters, classifier, lock run count and output strobes
  always_comb begin
    sync_d = {sync_q[1:0], bus.iPwm};
    rise = sync_q[1] & ~sync_q[2];
    fall = ~sync_q[1] & sync_q[2];
    timeout = (state_q != HIGH) && (gap_q == GAP_TO);
    clamp = width_q < W_MIN ? W_MIN : (width_q > W_MAX ? W_MAX : width_q);
    state_d = state_q;
    width_d = width_q;
    gap_d = state_q == HIGH ? gap_q : gap_q + 1'b1;
    run_d = done && run_q != RUN_FULL ? run_q + 1'b1 : run_q;
    err_req = 1'b0;
    start = 1'b0;
    case (state_q)
      IDLE, LOW: if (rise) begin
        state_d = HIGH;
        width_d = W'(1);
        gap_d = '0;
      end
      HIGH: if (fall) begin
        state_d = LOW;
        if (width_q < W_LO || width_q > W_HI) begin
          err_req = 1'b1;
          run_d = '0;
        end else begin
          start = 1'b1;
          err_req = busy;
        end
      end else if (width_q > W_HI) begin
        state_d = STUCK;
        err_req = 1'b1;
      end else begin
        width_d = &width_q ? width_q : width_q + 1'b1;
      end
      STUCK: if (fall) state_d = LOW;
      default: ;
    endcase
    if (timeout) begin
      run_d = '0;
      gap_d = '0;
      if (state_d != HIGH) state_d = IDLE;
    end
    err_any = err_req | pend_q;
    valid_d = done;
    err_d = err_any & ~done;
    pend_d = err_any & done;
    angle_d = done ? (quo > W_ANG ? ANGLE_BITS'(ANGLE_MAX) : quo[ANGLE_BITS-1:0]) : angle_q;
  end
  // state register; reset abandons any pulse being measured
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      sync_q <= '0;
      state_q <= IDLE;
      width_q <= '0;
      gap_q <= '0;
      run_q <= '0;
      angle_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      state_q <= state_d;
      width_q <= width_d;
      gap_q <= gap_d;
      run_q <= run_d;
      angle_q <= angle_d;
      valid_q <= valid_d;
      err_q <= err_d;
      pend_q <= pend_d;
    end
  end
  assign bus.oAngle = angle_q;
  assign bus.oValid = valid_q;
  assign bus.oErr = err_q;
  assign bus.oLocked = run_q == RUN_FULL;
endmodule
